// File: rtl/uart_detector_rx.sv
// 8N1 UART receiver for the detector link: samples each bit at its midpoint,
// publishes good bytes on rec and tracks link freshness with a stale counter.
module uart_detector_rx #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned STALE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rec,
    output logic       rec_valid,
    output logic       frame_err,
    output logic       link_ok
);

    localparam int unsigned CPB = CLK_FREQ / BAUD;
    localparam int unsigned CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int unsigned SW  = $clog2(STALE_CYCLES + 1);

    localparam logic [CW-1:0] HALF_CNT  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CPB - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;
    logic [7:0]    rec_d;
    logic          rec_valid_d, frame_err_d;
    logic          brk, brk_d;
    logic [SW-1:0] stale, stale_d;
    logic          link_ok_d;

    // Two-flop synchronizer, idle-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            brk       <= 1'b0;
            rec       <= 8'h00;
            rec_valid <= 1'b0;
            frame_err <= 1'b0;
            stale     <= '0;
            link_ok   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shreg     <= shreg_d;
            brk       <= brk_d;
            rec       <= rec_d;
            rec_valid <= rec_valid_d;
            frame_err <= frame_err_d;
            stale     <= stale_d;
            link_ok   <= link_ok_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = CW'(cnt + 1'b1);
        idx_d       = idx;
        shreg_d     = shreg;
        brk_d       = brk;
        rec_d       = rec;
        rec_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                brk_d = 1'b0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_d          = '0;
                    shreg_d[idx]   = rx_s;
                    if (idx == 3'd7) state_d = STOP;
                    else             idx_d   = 3'(idx + 1'b1);
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line is released
                if (brk) begin
                    cnt_d = cnt;
                    if (rx_s) begin
                        state_d = IDLE;
                        brk_d   = 1'b0;
                    end
                end else if (cnt == LAST_CNT) begin
                    if (rx_s) begin
                        rec_d       = shreg;
                        rec_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Freshness: a good byte clears the counter and wins over saturation
        if (rec_valid_d)              stale_d = '0;
        else if (stale == STALE_MAX)  stale_d = stale;
        else                          stale_d = SW'(stale + 1'b1);

        if (rec_valid_d)                link_ok_d = 1'b1;
        else if (stale_d == STALE_MAX)  link_ok_d = 1'b0;
        else                            link_ok_d = link_ok;
    end

endmodule

// File: tb/tb_uart_detector_rx.sv
// Bench for uart_detector_rx: directed frames, expected bytes queued at send
// time and checked by an independent monitor on each rec_valid pulse.
module tb_uart_detector_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned STALE    = 1000;
    localparam int          BIT_CYC  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rec;
    logic       rec_valid;
    logic       frame_err;
    logic       link_ok;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         act_ferr = 0;
    int         cyc = 0;
    int         last_rv_cyc = 0;
    logic [7:0] prev_rec = 8'h00;
    logic       prev_rst = 1'b0;

    uart_detector_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .STALE_CYCLES(STALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rec      (rec),
        .rec_valid(rec_valid),
        .frame_err(frame_err),
        .link_ok  (link_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops expected bytes, counts frame errors, guards rec stability
    always @(negedge clk) begin
        if (rst && prev_rst) begin
            if (rec_valid || frame_err)
                check("valid_err_exclusive", {31'd0, rec_valid & frame_err}, 32'd0);
            if (rec_valid) begin
                last_rv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rec_valid", {24'd0, rec}, 32'hFFFF_FFFF);
                end else begin
                    check("rec_byte", {24'd0, rec}, {24'd0, exp_q.pop_front()});
                    check("link_ok_on_valid", {31'd0, link_ok}, 32'd1);
                end
            end
            if (frame_err) act_ferr++;
            if (!rec_valid && rec !== prev_rec)
                check("rec_stable", {24'd0, rec}, {24'd0, prev_rec});
        end
        prev_rec = rec;
        prev_rst = rst;
    end

    task automatic bit_out(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int stop_cyc);
        bit_out(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) bit_out(d[i], BIT_CYC);
        bit_out(stop, stop_cyc);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rec", {24'd0, rec}, 32'h00);
        check("reset_rec_valid", {31'd0, rec_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_link_ok", {31'd0, link_ok}, 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("link_ok_before_frame", {31'd0, link_ok}, 32'd0);

        // Good frame: front (bit0) and left (bit2)
        exp_q.push_back(8'h05);
        send_byte(8'h05, 1'b1, BIT_CYC);
        drain("drain_05");
        repeat (8) @(negedge clk);
        check("front_left_bits", {29'd0, rec[3:0] == 4'b0101, 2'd0}, {29'd0, 1'b1, 2'd0});
        check("link_ok_after_05", {31'd0, link_ok}, 32'd1);

        // Back-to-back, no idle gap
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0C);
        send_byte(8'hA3, 1'b1, BIT_CYC);
        send_byte(8'h0C, 1'b1, BIT_CYC);
        drain("drain_b2b");
        repeat (20) @(negedge clk);

        // Framing error with 3-bit break, then a good byte
        exp_ferr++;
        send_byte(8'h0F, 1'b0, 3 * BIT_CYC);
        repeat (BIT_CYC) @(negedge clk);
        check("rec_kept_after_ferr", {24'd0, rec}, 32'h0C);
        exp_q.push_back(8'h02);
        send_byte(8'h02, 1'b1, BIT_CYC);
        drain("drain_02");
        check("frame_err_count", act_ferr, exp_ferr);
        repeat (20) @(negedge clk);

        // Glitch of 5 cycles must not start a frame; a following byte decodes
        bit_out(1'b0, 5);
        bit_out(1'b1, 40);
        check("glitch_no_ferr", act_ferr, exp_ferr);
        check("glitch_rec", {24'd0, rec}, 32'h02);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, BIT_CYC);
        drain("drain_55");
        repeat (20) @(negedge clk);

        // Reset during bit 4 of 0xFF
        bit_out(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) bit_out(1'b1, BIT_CYC);
        bit_out(1'b1, BIT_CYC / 2);
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        check("midreset_rec", {24'd0, rec}, 32'h00);
        check("midreset_link_ok", {31'd0, link_ok}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6 * BIT_CYC) @(negedge clk);
        check("midreset_no_update", {24'd0, rec}, 32'h00);
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1, BIT_CYC);
        drain("drain_01");

        // Stale: link_ok drops exactly STALE cycles after the last rec_valid
        begin
            int n;
            n = 0;
            while (cyc < last_rv_cyc + int'(STALE) - 1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("stale_wait_bound", {31'd0, n >= 2000}, 32'd0);
        end
        check("link_ok_before_stale", {31'd0, link_ok}, 32'd1);
        @(negedge clk);
        check("link_ok_stale", {31'd0, link_ok}, 32'd0);
        repeat (10) @(negedge clk);
        check("link_ok_still_stale", {31'd0, link_ok}, 32'd0);
        exp_q.push_back(8'h05);
        send_byte(8'h05, 1'b1, BIT_CYC);
        drain("drain_05b");
        check("link_ok_recovered", {31'd0, link_ok}, 32'd1);

        repeat (20) @(negedge clk);
        check("final_frame_err_count", act_ferr, exp_ferr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
